// File: rtl/xgcd_pkg.sv
// Shared constants for the APB binary GCD engine: register map, CTRL/STATUS bit
// positions, sequencer state encodings and the default ID word.
package xgcd_pkg;

    localparam logic [31:0] XGCD_ID_DEFAULT = 32'h5A5A_5A5A;

    // Word offsets (PADDR[11:2]) of the scalar registers
    localparam logic [9:0] OFF_ID     = 10'h000;
    localparam logic [9:0] OFF_CTRL   = 10'h001;
    localparam logic [9:0] OFF_STATUS = 10'h002;
    localparam logic [9:0] OFF_CYCLES = 10'h003;

    // Operand/result windows, selected by PADDR[11:8]
    localparam logic [3:0] REGION_A   = 4'h1;
    localparam logic [3:0] REGION_B   = 4'h2;
    localparam logic [3:0] REGION_RES = 4'h3;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned STAT_BUSY   = 0;
    localparam int unsigned STAT_DONE   = 1;
    localparam int unsigned STAT_ZERO   = 2;

    typedef logic [2:0] xgcd_state_t;

    localparam xgcd_state_t S_IDLE   = 3'd0;
    localparam xgcd_state_t S_LOAD   = 3'd1;
    localparam xgcd_state_t S_STRIP  = 3'd2;
    localparam xgcd_state_t S_ODDA   = 3'd3;
    localparam xgcd_state_t S_REDUCE = 3'd4;
    localparam xgcd_state_t S_SCALE  = 3'd5;
    localparam xgcd_state_t S_FIN    = 3'd6;

endpackage

// File: rtl/xgcd_binary_datapath.sv
// Binary (Stein) GCD sequencer: working registers a/b, common power-of-two count k,
// and the state machine that produces one result write per run.
module xgcd_binary_datapath
    import xgcd_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             start_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic             busy_o,
    output logic             load_o,
    output logic             fin_o,
    output logic             res_we_o,
    output logic             zero_err_o,
    output logic [WIDTH-1:0] res_o
);

    localparam int unsigned KW = $clog2(WIDTH) + 1;

    xgcd_state_t      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [KW-1:0]    k_q, k_d;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        k_d        = k_q;
        res_we_o   = 1'b0;
        zero_err_o = 1'b0;
        res_o      = '0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_LOAD;
            end
            S_LOAD: begin
                a_d = opa_i;
                b_d = opb_i;
                k_d = '0;
                if (opa_i == '0 || opb_i == '0) begin
                    // With A=0 the result is B, which also yields 0 for the both-zero case
                    res_we_o   = 1'b1;
                    zero_err_o = (opa_i == '0) && (opb_i == '0);
                    res_o      = (opa_i == '0) ? opb_i : opa_i;
                    state_d    = S_FIN;
                end else begin
                    state_d = S_STRIP;
                end
            end
            S_STRIP: begin
                if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + 1'b1;
                end else begin
                    state_d = S_ODDA;
                end
            end
            S_ODDA: begin
                if (!a_q[0]) a_d = a_q >> 1;
                else         state_d = S_REDUCE;
            end
            S_REDUCE: begin
                // a stays odd here; b is halved when even, otherwise replaced by |a-b|
                if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q < b_q) begin
                    b_d = b_q - a_q;
                end else begin
                    a_d = b_q;
                    b_d = a_q - b_q;
                end
                if (b_d == '0) state_d = S_SCALE;
            end
            S_SCALE: begin
                res_we_o = 1'b1;
                res_o    = a_q << k_q;
                state_d  = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign load_o = (state_q == S_LOAD);
    assign fin_o  = (state_q == S_FIN);

endmodule

// File: rtl/xgcd_apb_engine.sv
// APB register file, interrupt and trace pulses around the binary GCD datapath.
// Optional XGCD_CYCLE_COUNT_EN adds the CYCLES run-length register at 0x00C.
module xgcd_apb_engine
    import xgcd_pkg::*;
#(
    parameter int unsigned WIDTH    = 64,
    parameter logic [31:0] ID_VALUE = XGCD_ID_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic [31:0] PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        IRQ,
    output logic        START_OUT,
    output logic        DONE_OUT
);

    localparam int unsigned NW   = WIDTH / 32;
    localparam int unsigned IDXW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [5:0]  NW6  = 6'(NW);

    logic [NW-1:0][31:0] opa_q, opb_q, result_q;
    logic [31:0]         prdata_q;
    logic                pslverr_q, irq_en_q, done_q, zero_q;

    logic [9:0]       woff;
    logic [IDXW-1:0]  widx;
    logic             setup, wr, rd, in_range;
    logic             hit_ctrl, hit_status, hit_a, hit_b, hit_res;
    logic             busy, start, wr_err;
    logic [31:0]      rdata;
    logic             dp_load, dp_fin, dp_res_we, dp_zero;
    logic [WIDTH-1:0] dp_res;
    logic             unused_addr;

    assign unused_addr = ^{PADDR[31:12], PADDR[1:0]};

    assign woff       = PADDR[11:2];
    assign widx       = woff[IDXW-1:0];
    assign in_range   = (woff[5:0] < NW6);
    assign setup      = PSEL & ~PENABLE;
    assign wr         = setup & PWRITE;
    assign rd         = setup & ~PWRITE;
    assign hit_ctrl   = (woff == OFF_CTRL);
    assign hit_status = (woff == OFF_STATUS);
    assign hit_a      = (woff[9:6] == REGION_A) && in_range;
    assign hit_b      = (woff[9:6] == REGION_B) && in_range;
    assign hit_res    = (woff[9:6] == REGION_RES) && in_range;

    assign wr_err = wr & busy & (hit_a | hit_b | (hit_ctrl & PWDATA[CTRL_START]));
    assign start  = wr & hit_ctrl & PWDATA[CTRL_START] & ~busy;

    xgcd_binary_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .start_i    (start),
        .opa_i      (opa_q),
        .opb_i      (opb_q),
        .busy_o     (busy),
        .load_o     (dp_load),
        .fin_o      (dp_fin),
        .res_we_o   (dp_res_we),
        .zero_err_o (dp_zero),
        .res_o      (dp_res)
    );

`ifdef XGCD_CYCLE_COUNT_EN
    logic [31:0] cycles_q;

    // Start clears; each busy cycle (LOAD..FIN) adds one, sticking at all-ones
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)                        cycles_q <= '0;
        else if (start)                     cycles_q <= '0;
        else if (busy && (cycles_q != '1))  cycles_q <= cycles_q + 32'd1;
    end
`endif

    always_comb begin
        rdata = '0;
        if (woff == OFF_ID) rdata = ID_VALUE;
        if (hit_ctrl) rdata[CTRL_IRQ_EN] = irq_en_q;
        if (hit_status) begin
            rdata[STAT_BUSY] = busy;
            rdata[STAT_DONE] = done_q;
            rdata[STAT_ZERO] = zero_q;
        end
`ifdef XGCD_CYCLE_COUNT_EN
        if (woff == OFF_CYCLES) rdata = cycles_q;
`endif
        if (hit_a)   rdata = opa_q[widx];
        if (hit_b)   rdata = opb_q[widx];
        if (hit_res) rdata = result_q[widx];
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            zero_q    <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
        end else begin
            pslverr_q <= wr_err;
            if (rd) prdata_q <= rdata;
            if (wr && hit_ctrl) irq_en_q <= PWDATA[CTRL_IRQ_EN];
            if (wr && !busy && hit_a) opa_q[widx] <= PWDATA;
            if (wr && !busy && hit_b) opb_q[widx] <= PWDATA;
            if (dp_res_we) result_q <= dp_res;
            // Completion set takes priority over a same-cycle W1C
            if (dp_fin)                                     done_q <= 1'b1;
            else if (start)                                 done_q <= 1'b0;
            else if (wr && hit_status && PWDATA[STAT_DONE]) done_q <= 1'b0;
            if (dp_res_we && dp_zero)                       zero_q <= 1'b1;
            else if (start)                                 zero_q <= 1'b0;
            else if (wr && hit_status && PWDATA[STAT_ZERO]) zero_q <= 1'b0;
        end
    end

    assign PRDATA    = prdata_q;
    assign PREADY    = 1'b1;
    assign PSLVERR   = pslverr_q;
    assign IRQ       = done_q & irq_en_q;
    assign START_OUT = dp_load;
    assign DONE_OUT  = dp_fin;

endmodule
